// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit owning the HI/LO pair.
// Define MULDIV_FAST_MULT_EN for a single-cycle registered multiplier; division stays iterative.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic             op_mult,
    input  logic             op_multu,
    input  logic             op_div,
    input  logic             op_divu,
    input  logic             op_mthi,
    input  logic             op_mtlo,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mul_nxt, div_nxt, prod;
    logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   abs_a, abs_b, rem_n, quo, rmd;
    logic [WIDTH:0]     mul_sum, shifted;
    logic               mul_q, mul_d, neg_q, neg_d, nega_q, nega_d, dz_q, dz_d;
    logic               done_q, done_d, div0_q, div0_d;
    logic               md_op, is_mul, sgn, ge;

    assign md_op   = op_mult || op_multu || op_div || op_divu;
    assign is_mul  = op_mult || op_multu;
    assign sgn     = op_mult || (!op_multu && op_div);
    assign abs_a   = (sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign abs_b   = (sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    // acc holds {partial product | multiplier} or {partial remainder | dividend->quotient}
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & b_q};
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    assign shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, b_q};
    assign rem_n   = shifted[WIDTH-1:0] - (ge ? b_q : {WIDTH{1'b0}});
    assign div_nxt = {rem_n, acc_q[WIDTH-2:0], ge};
    assign prod    = neg_q ? -acc_q : acc_q;
    assign quo     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rmd     = nega_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        mul_d   = mul_q;
        neg_d   = neg_q;
        nega_d  = nega_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div0_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue && md_op) begin
`ifdef MULDIV_FAST_MULT_EN
                    state_d = is_mul ? FIX : RUN;
                    acc_d   = is_mul ? {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b}
                                     : {{WIDTH{1'b0}}, abs_a};
`else
                    state_d = RUN;
                    acc_d   = {{WIDTH{1'b0}}, abs_a};
`endif
                    cnt_d   = '0;
                    b_d     = abs_b;
                    mul_d   = is_mul;
                    neg_d   = sgn && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                    nega_d  = sgn && rs_data[WIDTH-1];
                    dz_d    = !is_mul && (rt_data == '0);
                end else if (issue) begin
                    hi_d = op_mthi ? rs_data : hi_q;
                    lo_d = op_mtlo ? rs_data : lo_q;
                end
            end
            RUN: begin
                acc_d   = mul_q ? mul_nxt : div_nxt;
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd31) ? FIX : RUN;
            end
            FIX: begin
                hi_d    = mul_q ? prod[2*WIDTH-1:WIDTH] : rmd;
                lo_d    = mul_q ? prod[WIDTH-1:0] : (dz_q ? {WIDTH{1'b1}} : quo);
                done_d  = 1'b1;
                div0_d  = dz_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            mul_q   <= 1'b0;
            neg_q   <= 1'b0;
            nega_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            mul_q   <= mul_d;
            neg_q   <= neg_d;
            nega_q  <= nega_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign div0 = div0_q;
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: table-driven vectors with a scoreboard queue, plus busy/mt*/reset sequences.
module tb_muldiv_hilo;
    localparam logic [5:0] MULT = 6'b100000, MULTU = 6'b010000, DIV = 6'b001000;
    localparam logic [5:0] DIVU = 6'b000100, MTHI = 6'b000010, MTLO = 6'b000001;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0, rst_n = 1'b0, issue = 1'b0;
    logic        op_mult = 1'b0, op_multu = 1'b0, op_div = 1'b0, op_divu = 1'b0;
    logic        op_mthi = 1'b0, op_mtlo = 1'b0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div0;

    muldiv_hilo #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .issue(issue),
        .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
        .op_mthi(op_mthi), .op_mtlo(op_mtlo), .rs_data(rs_data), .rt_data(rt_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
    );

    always #5 clk = ~clk;

    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    typedef struct {logic [31:0] hi, lo; logic d0; int lat; int t0;} exp_t;
    typedef struct {string name; logic [5:0] ops; logic [31:0] a, b, hi, lo; logic d0; int lat;} vec_t;
    exp_t sb[$];
    vec_t vt[14];
    int   errors = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input logic d0, input int lat);
        exp_t e;
        e.hi = h; e.lo = l; e.d0 = d0; e.lat = lat; e.t0 = ncyc;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [5:0] ops, input logic [31:0] a, input logic [31:0] b);
        {op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo} = ops;
        rs_data = a;
        rt_data = b;
        issue   = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        {op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo} = '0;
    endtask

    task automatic wait_done(input string name);
        logic [31:0] h0, l0;
        bit          bad;
        int          k;
        exp_t        e;
        h0 = hi; l0 = lo; bad = 0; k = 0;
        while (!done && k < 80) begin
            if (!busy || hi !== h0 || lo !== l0) bad = 1;
            @(negedge clk);
            k++;
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            if (done) begin
                chk({name, "_hi"}, 64'(hi), 64'(e.hi));
                chk({name, "_lo"}, 64'(lo), 64'(e.lo));
                chk({name, "_div0"}, 64'(div0), 64'(e.d0));
                chk({name, "_latency"}, 64'(ncyc - e.t0), 64'(e.lat));
                chk({name, "_busy_clr"}, 64'(busy), 64'd0);
                chk({name, "_run_stable"}, 64'(bad), 64'd0);
            end
        end
    endtask

    initial begin
        vt[0]  = '{"multu_max",  MULTU,      32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT};
        vt[1]  = '{"mult_min",   MULT,       32'h80000000, 32'h00000010, 32'hFFFFFFF8, 32'h00000000, 1'b0, MUL_LAT};
        vt[2]  = '{"mult_m1x5",  MULT,       32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, MUL_LAT};
        vt[3]  = '{"multu_2p32", MULTU,      32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, MUL_LAT};
        vt[4]  = '{"prio_mult",  MULT | DIV, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, MUL_LAT};
        vt[5]  = '{"prio_multu", MULTU | DIV, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, MUL_LAT};
        vt[6]  = '{"div_m7_2",   DIV,        32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT};
        vt[7]  = '{"divu_7_2",   DIVU,       32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, DIV_LAT};
        vt[8]  = '{"div_ovf",    DIV,        32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT};
        vt[9]  = '{"div_100_m7", DIV,        32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, DIV_LAT};
        vt[10] = '{"divu_big",   DIVU,       32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, DIV_LAT};
        vt[11] = '{"prio_div",   DIV | DIVU, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT};
        vt[12] = '{"div0_pos",   DIV,        32'h00000042, 32'h00000000, 32'h00000042, 32'hFFFFFFFF, 1'b1, DIV_LAT};
        vt[13] = '{"div0_neg",   DIV,        32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, DIV_LAT};

        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_div0", 64'(div0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            push(vt[i].hi, vt[i].lo, vt[i].d0, vt[i].lat);
            drive(vt[i].ops, vt[i].a, vt[i].b);
            wait_done(vt[i].name);
            @(negedge clk);
            chk({vt[i].name, "_done_pulse"}, 64'({done, div0}), 64'd0);
        end

        // ops issued while busy must be dropped
        push(32'h0, 32'hC, 1'b0, MUL_LAT);
        drive(MULTU, 32'h3, 32'h4);
        if (MUL_LAT > 2) begin
            repeat (4) @(negedge clk);
            drive(MTHI, 32'h1234, 32'h0);
            repeat (3) @(negedge clk);
            drive(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        end
        wait_done("busy_drop");
        drive(MTHI | MTLO, 32'h1234, 32'h5678);
        rs_data = 32'h5678;
        chk("mt_hi", 64'(hi), 64'h1234);
        drive(MTLO, 32'h5678, 32'h0);
        chk("mt_lo", 64'(lo), 64'h5678);
        chk("mt_no_done", 64'(done), 64'd0);
        begin
            bit spurious = 0;
            repeat (40) begin
                @(negedge clk);
                if (done || busy) spurious = 1;
            end
            chk("no_queued_op", 64'(spurious), 64'd0);
        end
        drive(MTHI | MTLO, 32'h00ABCDEF, 32'h0);
        chk("mt_both_hi", 64'(hi), 64'h00ABCDEF);
        chk("mt_both_lo", 64'(lo), 64'h00ABCDEF);

        // reset in the middle of a division
        drive(DIV, 32'h00000064, 32'h00000007);
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_hi", 64'(hi), 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(32'h0, 32'h3, 1'b0, DIV_LAT);
        drive(DIVU, 32'h9, 32'h3);
        wait_done("divu_9_3");
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
